tcp_tab_rd_arb: RTL and testbench
=================================

Name: tcp_tab_rd_arb

Overview:
- Shares the single read port of the TCP connection table RAM between NREQ requesters: TX table-request FIFO, RX lookup FIFO and CPU access FIFO.
- Pops table-read requests from each requester's show-ahead FIFO using round-robin arbitration and issues one read per cycle to the RAM.
- Tracks each read through the fixed RAM latency and writes the returned entry into the owning requester's response FIFO.
- Issue is gated per requester by response-FIFO almost-full and an in-flight credit limit.

Parameters:
- NREQ, 3, number of requesters; index 0 is the TX path.
- TAB_AWID, 12, table address width.
- TAB_DWID, 128, table entry width.
- RD_LAT, 2, RAM read latency in cycles, from tab_rd_en to tab_rd_dat valid; legal range 1..4.
- MAX_INFL, 4, maximum reads in flight per requester.
- DBG_WID, 32, debug bus width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_empty  in  NREQ  per-requester request FIFO empty
- req_rdata  in  NREQ*TAB_AWID  per-requester FIFO head address; requester i occupies slice [i*TAB_AWID +: TAB_AWID]
- req_ren  out  NREQ  per-requester FIFO pop, one-hot or zero
- tab_busy  in  1  table write engine owns the RAM; no issue while high
- tab_rd_en  out  1  RAM read strobe
- tab_rd_addr  out  TAB_AWID  RAM read address
- tab_rd_dat  in  TAB_DWID  RAM read data
- rsp_wen  out  NREQ  per-requester response FIFO write, one-hot or zero
- rsp_wdata  out  TAB_DWID  response data, shared by all requesters
- rsp_nafull  in  NREQ  per-requester response FIFO not-almost-full; 1 means space available
- dbg_sig  out  DBG_WID  debug/status

Behaviour:
- Reset: req_ren=0, tab_rd_en=0, tab_rd_addr=0, rsp_wen=0, rsp_wdata=0, rr_ptr=0, all in-flight counters=0, tag pipeline cleared, dbg_sig=0. Reset asserted mid-operation discards all in-flight reads; no rsp_wen for them after release.
- Eligibility: requester i is eligible when req_empty[i]=0, rsp_nafull[i]=1 and infl_cnt[i]<MAX_INFL.
- Arbitration is combinational from registered state. When tab_busy=0, grant the first eligible requester searching from rr_ptr upward with wrap-around, NREQ-1 -> 0.
- On a grant to g:
  - req_ren[g]=1 in the same cycle (show-ahead pop).
  - rr_ptr <= (g+1) mod NREQ.
  - Next cycle, registered: tab_rd_en=1 and tab_rd_addr=req_rdata[g].
- No grant: rr_ptr holds and tab_rd_en=0 next cycle.
- tab_busy=1 forces no grant and does not move rr_ptr.
- Tag pipeline: a valid bit plus requester id, shifted RD_LAT stages and aligned with tab_rd_dat. At pipeline exit: rsp_wen[id]<=1 and rsp_wdata<=tab_rd_dat, both registered.
- Latency: grant cycle T -> tab_rd_en at T+1 -> rsp_wen at T+1+RD_LAT+1.
- Throughput: one read per cycle, fully pipelined.
- infl_cnt[i] increments on grant to i and decrements on rsp_wen[i]. If both happen in the same cycle, the counter holds.
- Back-to-back grants to the same requester are allowed when it is the only eligible requester.
- rsp_nafull margin: the response FIFO must absorb MAX_INFL writes after nafull drops. The block never writes more than MAX_INFL entries beyond the last cycle it observed nafull=1.
- dbg_sig: [NREQ-1:0]=req_empty, [NREQ+1:NREQ]=rr_ptr, [8+:3*4]=infl_cnt per requester (NREQ<=3 mapped), [31]=tab_busy; all other bits 0.

Optional Feature:
- TCP_TAB_ARB_STAT_EN defined: adds a 16-bit saturating grant counter per requester and a 16-bit stall counter. The stall counter counts cycles with any requester non-empty but no grant. dbg_sig[31:16] is replaced by a read mux selected by rr_ptr; stall count is shown when rr_ptr=NREQ-1.
- Not defined: no counters are built and dbg_sig is as in Behaviour.

Decomposition:
- Shared package tcp_tab_pkg holds: TAB_AWID/TAB_DWID defaults, requester index constants (REQ_TX=0, REQ_RX=1, REQ_CPU=2), and the dbg_sig field offsets.
- One sub-module, rr_arb_nreq: round-robin grant logic with pointer update, parameterised by N. The tag pipeline and credit counters stay in the top level.

Test Plan:
- Single TX request, addr 0x0A5, RAM returns 0xDEAD…: req_ren[0] at T, tab_rd_en/addr 0x0A5 at T+1, rsp_wen=3'b001 with 0xDEAD… at T+4 (RD_LAT=2).
- All three FIFOs hold 4 entries: grant order 0,1,2,0,1,2,… with 12 consecutive tab_rd_en cycles, and each response lands on the correct rsp_wen bit.
- rsp_nafull[1]=0 with requester 1 non-empty: requester 1 is never granted and requesters 0 and 2 alternate. Raising nafull resumes requester 1 on the next rr_ptr visit.
- Only requester 2 active, response path stalled by holding the RAM via tab_busy after 4 grants: infl_cnt[2] reaches 4 and no 5th grant occurs until a rsp_wen[2] arrives.
- tab_busy=1 for 5 cycles during continuous requests: no req_ren or tab_rd_en during the window, rr_ptr unchanged, and the sequence resumes at the same requester.
- rst_n pulsed low with 2 reads in flight: all outputs go to 0 immediately, no rsp_wen after release, and counters restart from 0.

Source files
------------

// File: rtl/tcp_tab_pkg.sv
// Shared constants for the TCP connection-table read path: default widths,
// requester indices and dbg_sig field layout.
package tcp_tab_pkg;

    localparam int TAB_AWID_DEF = 12;
    localparam int TAB_DWID_DEF = 128;

    localparam int REQ_TX  = 0;
    localparam int REQ_RX  = 1;
    localparam int REQ_CPU = 2;

    localparam int DBG_EMPTY_LSB    = 0;
    localparam int DBG_INFL_LSB     = 8;
    localparam int DBG_INFL_W       = 4;
    localparam int DBG_INFL_MAX_REQ = 3;
    localparam int DBG_STAT_LSB     = 16;
    localparam int DBG_STAT_W       = 16;
    localparam int DBG_BUSY_BIT     = 31;

    // rr_ptr sits directly above the per-requester empty flags
    function automatic int dbg_ptr_lsb(input int nreq);
        return nreq;
    endfunction

endpackage

// File: rtl/rr_arb_nreq.sv
// Round-robin grant over N requesters; the search starts at the pointer and
// the pointer moves past the winner only when a grant is issued.
module rr_arb_nreq #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          vld,
    output logic [PW-1:0] idx,
    output logic [PW-1:0] ptr
);

    localparam int unsigned NU = N;

    int unsigned pos;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        pos = 0;
        if (en) begin
            for (int unsigned k = 0; k < NU; k++) begin
                pos = 32'(ptr) + k;
                if (pos >= NU) pos = pos - NU;
                if (!vld && req[pos]) begin
                    vld = 1'b1;
                    idx = PW'(pos);
                end
            end
        end
        gnt[idx] = vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (vld) begin
            ptr <= (32'(idx) == NU - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tcp_tab_rd_arb.sv
// Shares the connection-table RAM read port between NREQ request FIFOs and
// routes each returned entry to its requester. Optional: TCP_TAB_ARB_STAT_EN.
module tcp_tab_rd_arb
    import tcp_tab_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int TAB_AWID = TAB_AWID_DEF,
    parameter int TAB_DWID = TAB_DWID_DEF,
    parameter int RD_LAT   = 2,
    parameter int MAX_INFL = 4,
    parameter int DBG_WID  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_empty,
    input  logic [NREQ*TAB_AWID-1:0] req_rdata,
    output logic [NREQ-1:0]          req_ren,
    input  logic                     tab_busy,
    output logic                     tab_rd_en,
    output logic [TAB_AWID-1:0]      tab_rd_addr,
    input  logic [TAB_DWID-1:0]      tab_rd_dat,
    output logic [NREQ-1:0]          rsp_wen,
    output logic [TAB_DWID-1:0]      rsp_wdata,
    input  logic [NREQ-1:0]          rsp_nafull,
    output logic [DBG_WID-1:0]       dbg_sig
);

    localparam int PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW          = $clog2(MAX_INFL + 1);
    localparam int DBG_PTR_LSB = dbg_ptr_lsb(NREQ);
    localparam int NDBG        = (NREQ < DBG_INFL_MAX_REQ) ? NREQ : DBG_INFL_MAX_REQ;

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    gnt;
    logic               gnt_vld;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      rr_ptr;
    logic [CW-1:0]      infl_cnt [NREQ];
    logic               tag_vld  [RD_LAT+1];
    logic [PW-1:0]      tag_id   [RD_LAT+1];
    logic [DBG_WID-1:0] dbg_nxt;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = !req_empty[i] && rsp_nafull[i] && (infl_cnt[i] < CW'(MAX_INFL));
        end
    end

    // gating with rst_n keeps the show-ahead pop quiet while reset is held
    rr_arb_nreq #(.N(NREQ), .PW(PW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n & ~tab_busy),
        .req   (elig),
        .gnt   (gnt),
        .vld   (gnt_vld),
        .idx   (gnt_idx),
        .ptr   (rr_ptr)
    );

    assign req_ren   = gnt;
    assign tab_rd_en = tag_vld[0];

    // stage 0 is the RAM strobe cycle; stage RD_LAT lines up with tab_rd_dat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
            tab_rd_addr <= '0;
            rsp_wen     <= '0;
            rsp_wdata   <= '0;
        end else begin
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_idx;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            if (gnt_vld) tab_rd_addr <= req_rdata[gnt_idx*TAB_AWID +: TAB_AWID];
            rsp_wen <= '0;
            if (tag_vld[RD_LAT]) begin
                rsp_wen[tag_id[RD_LAT]] <= 1'b1;
                rsp_wdata               <= tab_rd_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) infl_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt[i] && !rsp_wen[i])      infl_cnt[i] <= infl_cnt[i] + 1'b1;
                else if (!gnt[i] && rsp_wen[i]) infl_cnt[i] <= infl_cnt[i] - 1'b1;
            end
        end
    end

`ifdef TCP_TAB_ARB_STAT_EN
    logic [DBG_STAT_W-1:0] gnt_cnt [NREQ];
    logic [DBG_STAT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) gnt_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt[i] && gnt_cnt[i] != '1) gnt_cnt[i] <= gnt_cnt[i] + 1'b1;
            end
            if (!(&req_empty) && !gnt_vld && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        dbg_nxt = '0;
        dbg_nxt[DBG_EMPTY_LSB +: NREQ] = req_empty;
        dbg_nxt[DBG_PTR_LSB +: PW]     = rr_ptr;
        for (int unsigned i = 0; i < NDBG; i++) begin
            dbg_nxt[DBG_INFL_LSB + DBG_INFL_W*i +: DBG_INFL_W] = DBG_INFL_W'(infl_cnt[i]);
        end
`ifdef TCP_TAB_ARB_STAT_EN
        dbg_nxt[DBG_STAT_LSB +: DBG_STAT_W] = (32'(rr_ptr) == NREQ - 1) ? stall_cnt : gnt_cnt[rr_ptr];
`else
        dbg_nxt[DBG_BUSY_BIT] = tab_busy;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_sig <= '0;
        else        dbg_sig <= dbg_nxt;
    end

endmodule

// File: tb/tb_tcp_tab_rd_arb.sv
// Bench for tcp_tab_rd_arb: FIFO/RAM models, grant-predicting scoreboard,
// an arbitration vector table and directed multi-cycle sequences.
module tb_tcp_tab_rd_arb;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 128;
    localparam int LAT  = 2;
    localparam int MAXI = 4;
    localparam int DBW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_empty;
    logic [NREQ*AW-1:0] req_rdata;
    logic [NREQ-1:0]   req_ren;
    logic              tab_busy;
    logic              tab_rd_en;
    logic [AW-1:0]     tab_rd_addr;
    logic [DW-1:0]     tab_rd_dat;
    logic [NREQ-1:0]   rsp_wen;
    logic [DW-1:0]     rsp_wdata;
    logic [NREQ-1:0]   rsp_nafull;
    logic [DBW-1:0]    dbg_sig;

    always #5 clk = ~clk;

    tcp_tab_rd_arb #(
        .NREQ(NREQ), .TAB_AWID(AW), .TAB_DWID(DW),
        .RD_LAT(LAT), .MAX_INFL(MAXI), .DBG_WID(DBW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_empty(req_empty), .req_rdata(req_rdata),
        .req_ren(req_ren), .tab_busy(tab_busy), .tab_rd_en(tab_rd_en),
        .tab_rd_addr(tab_rd_addr), .tab_rd_dat(tab_rd_dat), .rsp_wen(rsp_wen),
        .rsp_wdata(rsp_wdata), .rsp_nafull(rsp_nafull), .dbg_sig(dbg_sig)
    );

    typedef struct { int unsigned due; logic [AW-1:0] addr; } iss_t;
    typedef struct { int unsigned due; int unsigned id; logic [DW-1:0] dat; } rsp_t;
    typedef struct { int unsigned c; int unsigned id; } glog_t;
    typedef struct { int unsigned c; logic [DW-1:0] dat; } rlog_t;
    typedef struct { logic [2:0] push; logic busy; logic [2:0] naf; logic [2:0] gnt; } vec_t;

    logic [AW-1:0] fq [NREQ][$];
    iss_t          iss_q[$];
    rsp_t          rsp_q[$];
    glog_t         glog[$];
    rlog_t         rlog[$];
    vec_t          tbl[13];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          m_rr;
    int          m_infl[NREQ];
    logic        rv1, rv2;
    logic [AW-1:0] ra1, ra2;
    logic        obs_en;
    logic [NREQ-1:0] obs_ren;
    int          en_run, en_max, en_cnt;
    int unsigned infl2_max;
    int unsigned t0;
    int unsigned exp_off[6] = '{0, 1, 2, 3, 5, 6};

    function automatic logic [DW-1:0] ent(input logic [AW-1:0] a);
        return {16'hDEAD, 4'h0, a, 32'hBEEF_0000 | {20'h0, a}, ~{20'h0, a}, 32'hC0DE_0000 ^ {20'h0, a}};
    endfunction

    function automatic int unsigned oh2id(input logic [NREQ-1:0] v);
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive_in();
        for (int i = 0; i < NREQ; i++) begin
            req_empty[i] = (fq[i].size() == 0);
            req_rdata[i*AW +: AW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
        tab_rd_dat = rv2 ? ent(ra2) : '0;
    endtask

    task automatic flush_model();
        iss_q.delete();
        rsp_q.delete();
        m_rr = 0;
        for (int i = 0; i < NREQ; i++) m_infl[i] = 0;
    endtask

    task automatic reset_chk();
        chk("rst_req_ren", DW'(req_ren), '0);
        chk("rst_tab_rd_en", DW'(tab_rd_en), '0);
        chk("rst_tab_rd_addr", DW'(tab_rd_addr), '0);
        chk("rst_rsp_wen", DW'(rsp_wen), '0);
        chk("rst_rsp_wdata", rsp_wdata, '0);
        chk("rst_dbg_sig", DW'(dbg_sig), '0);
    endtask

    // One clock: predict and check at the falling edge, then advance models.
    task automatic cycle();
        int              g;
        logic [NREQ-1:0] exp_ren;
        logic [NREQ-1:0] exp_wen;
        logic            cap_en;
        logic [AW-1:0]   cap_a;
        @(negedge clk);
        g = -1;
        if (rst_n && !tab_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (g < 0 && fq[j].size() != 0 && rsp_nafull[j] && m_infl[j] < MAXI) g = j;
            end
        end
        exp_ren = '0;
        if (g >= 0) exp_ren[g] = 1'b1;
        obs_ren = req_ren;
        obs_en  = tab_rd_en;
        chk("req_ren", DW'(req_ren), DW'(exp_ren));
        if (req_ren != '0) glog.push_back('{cyc, oh2id(req_ren)});
        if (rsp_wen != '0) rlog.push_back('{cyc, rsp_wdata});

        if (iss_q.size() != 0 && iss_q[0].due == cyc) begin
            chk("tab_rd_en", DW'(tab_rd_en), DW'(1));
            chk("tab_rd_addr", DW'(tab_rd_addr), DW'(iss_q[0].addr));
            void'(iss_q.pop_front());
        end else begin
            chk("tab_rd_en", DW'(tab_rd_en), '0);
        end

        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            exp_wen = '0;
            exp_wen[rsp_q[0].id] = 1'b1;
            chk("rsp_wen", DW'(rsp_wen), DW'(exp_wen));
            chk("rsp_wdata", rsp_wdata, rsp_q[0].dat);
            m_infl[rsp_q[0].id]--;
            void'(rsp_q.pop_front());
        end else begin
            chk("rsp_wen", DW'(rsp_wen), '0);
        end

        if (tab_rd_en) en_run++; else en_run = 0;
        if (en_run > en_max) en_max = en_run;
        if (32'(dbg_sig[19:16]) > infl2_max) infl2_max = 32'(dbg_sig[19:16]);
        cap_en = tab_rd_en;
        cap_a  = tab_rd_addr;

        if (g >= 0) begin
            iss_q.push_back('{cyc + 1, fq[g][0]});
            rsp_q.push_back('{cyc + 2 + LAT, g, ent(fq[g][0])});
            m_infl[g]++;
            m_rr = (g + 1) % NREQ;
            void'(fq[g].pop_front());
        end

        @(posedge clk);
        #1;
        cyc++;
        rv2 = rv1; ra2 = ra1;
        rv1 = cap_en; ra1 = cap_a;
        drive_in();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tab_busy = 1'b0;
        rsp_nafull = '1;
        for (int i = 0; i < NREQ; i++) fq[i].delete();
        flush_model();
        drive_in();
        #1;
        reset_chk();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 3'b111, 3'b000};
        tbl[1]  = '{3'b001, 1'b0, 3'b111, 3'b001};
        tbl[2]  = '{3'b110, 1'b0, 3'b111, 3'b010};
        tbl[3]  = '{3'b001, 1'b0, 3'b111, 3'b100};
        tbl[4]  = '{3'b000, 1'b1, 3'b111, 3'b000};
        tbl[5]  = '{3'b000, 1'b0, 3'b111, 3'b001};
        tbl[6]  = '{3'b011, 1'b0, 3'b101, 3'b001};
        tbl[7]  = '{3'b000, 1'b0, 3'b101, 3'b000};
        tbl[8]  = '{3'b000, 1'b0, 3'b111, 3'b010};
        tbl[9]  = '{3'b111, 1'b0, 3'b111, 3'b100};
        tbl[10] = '{3'b000, 1'b0, 3'b111, 3'b001};
        tbl[11] = '{3'b000, 1'b0, 3'b111, 3'b010};
        tbl[12] = '{3'b000, 1'b0, 3'b111, 3'b000};

        rst_n = 1'b1; tab_busy = 1'b0; rsp_nafull = '1;
        rv1 = 1'b0; rv2 = 1'b0; ra1 = '0; ra2 = '0;
        en_run = 0; en_max = 0; infl2_max = 0;
        flush_model();
        drive_in();
        @(posedge clk);
        #1;
        do_reset();

        // arbitration vectors
        for (int r = 0; r < 13; r++) begin
            tab_busy   = tbl[r].busy;
            rsp_nafull = tbl[r].naf;
            for (int i = 0; i < NREQ; i++)
                if (tbl[r].push[i]) fq[i].push_back(AW'(12'h100 + r*16 + i));
            drive_in();
            cycle();
            chk($sformatf("tbl%0d_gnt", r), DW'(obs_ren), DW'(tbl[r].gnt));
        end
        tab_busy = 1'b0; rsp_nafull = '1;
        repeat (8) cycle();

        // single TX read: grant T, strobe T+1, response T+4
        do_reset();
        fq[0].push_back(12'h0A5);
        drive_in();
        glog.delete(); rlog.delete();
        t0 = cyc;
        repeat (8) cycle();
        chk("s1_ngnt", DW'(glog.size()), DW'(1));
        chk("s1_nrsp", DW'(rlog.size()), DW'(1));
        if (glog.size() != 0) chk("s1_gnt_cyc", DW'(glog[0].c - t0), '0);
        if (rlog.size() != 0) begin
            chk("s1_rsp_cyc", DW'(rlog[0].c - t0), DW'(4));
            chk("s1_rsp_dat", rlog[0].dat, 128'hDEAD00A5_BEEF00A5_FFFFFF5A_C0DE00A5);
        end

        // all three FIFOs four deep
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) fq[i].push_back(AW'(12'h200 + i*16 + k));
        drive_in();
        glog.delete(); en_run = 0; en_max = 0;
        repeat (20) cycle();
        chk("s2_ngnt", DW'(glog.size()), DW'(12));
        for (int k = 0; k < glog.size(); k++) begin
            chk("s2_gnt_id", DW'(glog[k].id), DW'(k % 3));
            chk("s2_gnt_cyc", DW'(glog[k].c - glog[0].c), DW'(k));
        end
        chk("s2_en_run", DW'(en_max), DW'(12));

        // requester 1 held off by almost-full, then released
        do_reset();
        rsp_nafull = 3'b101;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 3; k++) fq[i].push_back(AW'(12'h300 + i*16 + k));
        drive_in();
        glog.delete();
        repeat (8) cycle();
        chk("s3_ngnt", DW'(glog.size()), DW'(6));
        for (int k = 0; k < glog.size(); k++)
            chk("s3_gnt_id", DW'(glog[k].id), DW'((k % 2 == 0) ? 0 : 2));
        rsp_nafull = '1;
        glog.delete();
        repeat (8) cycle();
        chk("s3_resume_ngnt", DW'(glog.size()), DW'(3));
        for (int k = 0; k < glog.size(); k++) chk("s3_resume_id", DW'(glog[k].id), DW'(1));

        // credit limit on a lone requester
        do_reset();
        for (int k = 0; k < 6; k++) fq[2].push_back(AW'(12'h400 + k));
        drive_in();
        glog.delete(); infl2_max = 0;
        repeat (12) cycle();
        chk("s4_ngnt", DW'(glog.size()), DW'(6));
        for (int k = 0; k < glog.size() && k < 6; k++) begin
            chk("s4_gnt_id", DW'(glog[k].id), DW'(2));
            chk("s4_gnt_off", DW'(glog[k].c - glog[0].c), DW'(exp_off[k]));
        end
        chk("s4_infl_max", DW'(infl2_max), DW'(4));

        // tab_busy window during continuous requests
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 6; k++) fq[i].push_back(AW'(12'h500 + i*16 + k));
        drive_in();
        glog.delete();
        repeat (2) cycle();
        chk("s5_pre_ngnt", DW'(glog.size()), DW'(2));
        tab_busy = 1'b1;
        glog.delete(); en_cnt = 0;
        for (int w = 0; w < 5; w++) begin
            cycle();
            if (w >= 1 && obs_en) en_cnt++;
        end
        chk("s5_busy_ngnt", DW'(glog.size()), '0);
        chk("s5_busy_en", DW'(en_cnt), '0);
        chk("s5_rr_ptr", DW'(dbg_sig[4:3]), DW'(2));
        chk("s5_busy_dbg", DW'(dbg_sig[31]), DW'(1));
        tab_busy = 1'b0;
        repeat (3) cycle();
        chk("s5_resume_ngnt", DW'(glog.size()), DW'(3));
        for (int k = 0; k < glog.size(); k++)
            chk("s5_resume_id", DW'(glog[k].id), DW'((k + 2) % 3));
        repeat (24) cycle();

        // reset with two reads in flight
        do_reset();
        for (int k = 0; k < 4; k++) fq[0].push_back(AW'(12'h600 + k));
        drive_in();
        repeat (2) cycle();
        chk("s6_inflight_en", DW'(tab_rd_en), DW'(1));
        rst_n = 1'b0;
        flush_model();
        #1;
        reset_chk();
        cycle();
        cycle();
        rst_n = 1'b1;
        glog.delete(); rlog.delete();
        repeat (10) cycle();
        chk("s6_ngnt", DW'(glog.size()), DW'(2));
        chk("s6_nrsp", DW'(rlog.size()), DW'(2));
        if (rlog.size() == 2) begin
            chk("s6_rsp0", rlog[0].dat, ent(12'h602));
            chk("s6_rsp1", rlog[1].dat, ent(12'h603));
        end
        chk("s6_infl_zero", DW'(dbg_sig[19:8]), '0);

        chk("sb_empty", DW'(iss_q.size() + rsp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
